start_req_feeder: RTL and testbench

Upstream stage for mkDesign_02. Buffers operand pairs from a producer in a small FIFO and drives them into the design's start(a,b) action method. After each start it calls the variable_check(d) actionvalue method and captures the returned value. Uses the same EN/RDY method handshake the design exposes.

---
 rtl/start_feeder_pkg.sv | 25 ++
 rtl/start_req_feeder_if.sv | 35 +++
 rtl/start_feeder_fifo.sv | 42 ++++
 rtl/start_req_feeder.sv | 110 +++++++++++
 tb/tb_start_req_feeder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/start_feeder_pkg.sv
// Shared types for the start(a,b) request feeder: FSM states, buffered entry, counter limit.
// Ports: none (package only).
// Imported by start_req_feeder and start_feeder_fifo users.
package start_feeder_pkg;

   // Operand width of the attached design's start/variable_check methods.
   localparam int OP_W = 5;

   // Ceiling for the optional saturating statistics counters.
   localparam logic [15:0] SAT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CHECK = 2'd2
   } state_t;

   // One buffered request: start operands plus the variable_check argument.
   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
      logic [OP_W-1:0] d;
   } entry_t;

endpackage

// File: rtl/start_req_feeder_if.sv
// Producer, design-method and result signals of the feeder grouped in one bundle.
// slave modport: the feeder itself; master modport: producer plus design side.
// Names match the design's EN/RDY method ports.
interface start_req_feeder_if #(
   parameter int W = 5
);
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [W-1:0] in_d;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] start_a;
   logic [W-1:0] start_b;
   logic         EN_start;
   logic         RDY_start;
   logic [W-1:0] variable_check_d;
   logic         EN_variable_check;
   logic         RDY_variable_check;
   logic [W-1:0] variable_check;
   logic [W-1:0] res_data;
   logic         res_valid;
   logic         busy;

   modport slave (
      input  in_a, in_b, in_d, in_valid, RDY_start, RDY_variable_check, variable_check,
      output in_ready, start_a, start_b, EN_start, variable_check_d, EN_variable_check,
             res_data, res_valid, busy
   );

   modport master (
      output in_a, in_b, in_d, in_valid, RDY_start, RDY_variable_check, variable_check,
      input  in_ready, start_a, start_b, EN_start, variable_check_d, EN_variable_check,
             res_data, res_valid, busy
   );
endinterface

// File: rtl/start_feeder_fifo.sv
// Generic DW x DEPTH FIFO; registered pointers with an extra wrap bit, read data from head.
// Latency: a push is visible at the head (empty=0) one cycle later.
// Backpressure: caller must gate push with !full and pop with !empty.
module start_feeder_fifo #(
   parameter int DW    = 15,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_dat,
   input  logic          pop,
   output logic [DW-1:0] pop_dat,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

   assign pop_dat = mem[rd_ptr[AW-1:0]];
   assign empty   = (wr_ptr == rd_ptr);
   // Same slot index but different lap means the writer is a full lap ahead.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/start_req_feeder.sv
// Buffers {a,b,d} pairs, calls the design's start(a,b) then variable_check(d) and captures the result.
// Latency: push to EN_start 2 cycles, result (res_valid) 2 cycles later; one pair per 3 cycles max.
// Backpressure: in_ready = FIFO not full; RDY_start/RDY_variable_check low stall the FSM in place.
// Ports: CLK, RST_N (async active-low), bus (slave modport: producer in_*, design method
// signals, res_data/res_valid, busy). With START_FEEDER_STATS_EN defined, adds
// pair_count and stall_cycles (16-bit saturating counters).
module start_req_feeder
   import start_feeder_pkg::*;
#(
   parameter int W     = OP_W,   // entry_t layout is sized by OP_W; keep W equal to it
   parameter int DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   start_req_feeder_if.slave bus
`ifdef START_FEEDER_STATS_EN
   ,
   output logic [15:0]       pair_count,
   output logic [15:0]       stall_cycles
`endif
);
   state_t         state;
   state_t         state_nxt;
   entry_t         hold;
   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_push;
   logic           fifo_pop;
   logic [3*W-1:0] fifo_head;
   logic           en_start;
   logic           en_check;

   assign bus.in_ready = !fifo_full;
   assign fifo_push    = bus.in_valid && !fifo_full;
   // Head is only consumed from IDLE, so at most one pair is ever held outside the FIFO.
   assign fifo_pop     = (state == IDLE) && !fifo_empty;

   start_feeder_fifo #(
      .DW    (3*W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (CLK),
      .rst_n    (RST_N),
      .push     (fifo_push),
      .push_dat ({bus.in_a, bus.in_b, bus.in_d}),
      .pop      (fifo_pop),
      .pop_dat  (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= IDLE;
         hold          <= '0;
         bus.res_data  <= '0;
         bus.res_valid <= 1'b0;
      end else begin
         state         <= state_nxt;
         if (fifo_pop) hold <= fifo_head;
         if (en_check) bus.res_data <= bus.variable_check;
         bus.res_valid <= en_check;
      end
   end

   // EN_* follow RDY combinationally, so a method never fires without its RDY
   // and ISSUE/CHECK are exclusive states, so the two enables never overlap.
   always_comb begin
      state_nxt = state;
      en_start  = 1'b0;
      en_check  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) state_nxt = ISSUE;
         end
         ISSUE: begin
            en_start = bus.RDY_start;
            if (bus.RDY_start) state_nxt = CHECK;
         end
         CHECK: begin
            en_check = bus.RDY_variable_check;
            if (bus.RDY_variable_check) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.EN_start          = en_start;
   assign bus.EN_variable_check = en_check;
   assign bus.start_a           = hold.a;
   assign bus.start_b           = hold.b;
   assign bus.variable_check_d  = hold.d;
   assign bus.busy              = (state != IDLE) || !fifo_empty;

`ifdef START_FEEDER_STATS_EN
   logic stall_now;
   assign stall_now = ((state == ISSUE) && !bus.RDY_start) ||
                      ((state == CHECK) && !bus.RDY_variable_check);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pair_count   <= '0;
         stall_cycles <= '0;
      end else begin
         if (en_check && (pair_count != SAT_MAX))    pair_count   <= pair_count + 1'b1;
         if (stall_now && (stall_cycles != SAT_MAX)) stall_cycles <= stall_cycles + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_start_req_feeder.sv
// Self-checking bench for start_req_feeder: cycle vectors, hand sequences, random scoreboard.
module tb_start_req_feeder;
   localparam int W     = 5;
   localparam int DEPTH = 4;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;

   start_req_feeder_if #(.W(W)) bus ();

`ifdef START_FEEDER_STATS_EN
   logic [15:0] pair_count;
   logic [15:0] stall_cycles;
`endif

   start_req_feeder #(.W(W), .DEPTH(DEPTH)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
`ifdef START_FEEDER_STATS_EN
      ,
      .pair_count   (pair_count),
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 CLK = ~CLK;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // {EN_start, EN_variable_check, start_a, start_b, variable_check_d, res_valid, res_data, in_ready, busy}
   function automatic logic [31:0] outs();
      return {7'd0, bus.EN_start, bus.EN_variable_check, bus.start_a, bus.start_b,
              bus.variable_check_d, bus.res_valid, bus.res_data, bus.in_ready, bus.busy};
   endfunction

   typedef struct {
      logic        vld;
      logic [4:0]  a, b, d;
      logic        rs, rv;
      logic [4:0]  vc;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic vld, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input logic rs, input logic rv, input logic [4:0] vc,
                      input logic es, input logic ev, input logic [4:0] sa, input logic [4:0] sb,
                      input logic [4:0] sd, input logic rvl, input logic [4:0] rd,
                      input logic ir, input logic bs);
      vec_t v;
      v.vld = vld; v.a = a; v.b = b; v.d = d; v.rs = rs; v.rv = rv; v.vc = vc;
      v.exp = {7'd0, es, ev, sa, sb, sd, rvl, rd, ir, bs};
      vecs.push_back(v);
   endtask

   task automatic run_vecs(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge CLK); #1;
         bus.in_valid           = vecs[i].vld;
         bus.in_a               = vecs[i].a;
         bus.in_b               = vecs[i].b;
         bus.in_d               = vecs[i].d;
         bus.RDY_start          = vecs[i].rs;
         bus.RDY_variable_check = vecs[i].rv;
         bus.variable_check     = vecs[i].vc;
         @(negedge CLK);
         chk($sformatf("%s_c%0d", tag, i), outs(), vecs[i].exp);
      end
      vecs.delete();
   endtask

   // Transaction-level reference: pairs leave in push order, each start is followed by
   // exactly one check carrying the same d, and the check's return appears one cycle later.
   typedef struct { logic [4:0] a, b, d; } pr_t;
   pr_t        expq[$];
   pr_t        pend;
   bit         pend_v  = 0;
   bit         res_due = 0;
   logic [4:0] res_exp = '0;

   task automatic sb_cycle();
      pr_t p;
      if (expq.size() < DEPTH)      chk("rnd_in_ready_hi", bus.in_ready, 1);
      else if (expq.size() > DEPTH) chk("rnd_in_ready_lo", bus.in_ready, 0);
      if (expq.size() > 0 || pend_v) chk("rnd_busy", bus.busy, 1);
      if (bus.EN_start)          chk("rnd_en_start_rdy", bus.RDY_start, 1);
      if (bus.EN_variable_check) chk("rnd_en_check_rdy", bus.RDY_variable_check, 1);
      chk("rnd_en_exclusive", bus.EN_start & bus.EN_variable_check, 0);
      chk("rnd_res_valid", bus.res_valid, res_due);
      if (res_due) chk("rnd_res_data", bus.res_data, res_exp);
      res_due = 0;
      if (bus.EN_start) begin
         chk("rnd_start_has_pair", (expq.size() > 0) && !pend_v, 1);
         if (expq.size() > 0) begin
            p = expq.pop_front();
            chk("rnd_start_a", bus.start_a, p.a);
            chk("rnd_start_b", bus.start_b, p.b);
            pend   = p;
            pend_v = 1;
         end
      end
      if (bus.EN_variable_check) begin
         chk("rnd_check_after_start", pend_v, 1);
         if (pend_v) chk("rnd_check_d", bus.variable_check_d, pend.d);
         pend_v  = 0;
         res_due = 1;
         res_exp = bus.variable_check;
      end
      if (bus.in_valid && bus.in_ready) begin
         p.a = bus.in_a; p.b = bus.in_b; p.d = bus.in_d;
         expq.push_back(p);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         acc;
      int         got;
      int         cyc;
      int         last_t;
      logic [4:0] rd_seen [$];
      int         t_seen [$];

      bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_d = '0;
      bus.RDY_start = 1; bus.RDY_variable_check = 1; bus.variable_check = '0;

      // ---- reset state ----
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("reset_state", outs(), 32'h0000_0002);
      RST_N = 1;

      // ---- basic transaction: push 03/1C/0A, return 11 ----
      //  vld a     b     d     rs rv vc      es ev sa    sb    sd    rvl rd    ir bs
      add(1, 5'h03, 5'h1C, 5'h0A, 1, 1, 5'h11, 0, 0, 5'h00, 5'h00, 5'h00, 0, 5'h00, 1, 0);
      add(0, 5'h00, 5'h00, 5'h00, 1, 1, 5'h11, 0, 0, 5'h00, 5'h00, 5'h00, 0, 5'h00, 1, 1);
      add(0, 5'h00, 5'h00, 5'h00, 1, 1, 5'h11, 1, 0, 5'h03, 5'h1C, 5'h0A, 0, 5'h00, 1, 1);
      add(0, 5'h00, 5'h00, 5'h00, 1, 1, 5'h11, 0, 1, 5'h03, 5'h1C, 5'h0A, 0, 5'h00, 1, 1);
      add(0, 5'h00, 5'h00, 5'h00, 1, 1, 5'h11, 0, 0, 5'h03, 5'h1C, 5'h0A, 1, 5'h11, 1, 0);
      add(0, 5'h00, 5'h00, 5'h00, 1, 1, 5'h11, 0, 0, 5'h03, 5'h1C, 5'h0A, 0, 5'h11, 1, 0);
      // ---- RDY_start low 10 cycles, then RDY_variable_check low 3 cycles ----
      add(1, 5'h10, 5'h11, 5'h12, 0, 1, 5'h00, 0, 0, 5'h03, 5'h1C, 5'h0A, 0, 5'h11, 1, 0);
      add(0, 5'h00, 5'h00, 5'h00, 0, 1, 5'h00, 0, 0, 5'h03, 5'h1C, 5'h0A, 0, 5'h11, 1, 1);
      for (int k = 0; k < 10; k++)
         add(0, 5'h00, 5'h00, 5'h00, 0, 1, 5'h00, 0, 0, 5'h10, 5'h11, 5'h12, 0, 5'h11, 1, 1);
      add(0, 5'h00, 5'h00, 5'h00, 1, 0, 5'h00, 1, 0, 5'h10, 5'h11, 5'h12, 0, 5'h11, 1, 1);
      for (int k = 0; k < 3; k++)
         add(0, 5'h00, 5'h00, 5'h00, 1, 0, 5'h1F, 0, 0, 5'h10, 5'h11, 5'h12, 0, 5'h11, 1, 1);
      add(0, 5'h00, 5'h00, 5'h00, 1, 1, 5'h07, 0, 1, 5'h10, 5'h11, 5'h12, 0, 5'h11, 1, 1);
      add(0, 5'h00, 5'h00, 5'h00, 1, 1, 5'h00, 0, 0, 5'h10, 5'h11, 5'h12, 1, 5'h07, 1, 0);
      run_vecs("vec");

`ifdef START_FEEDER_STATS_EN
      chk("stat_pair_count", pair_count, 2);
      chk("stat_stall_cycles", stall_cycles, 13);
`endif

      // ---- fill: with start stalled, DEPTH in FIFO plus one held ----
      bus.RDY_start = 0;
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge CLK); #1;
         bus.in_valid = 1;
         bus.in_a = 5'(acc); bus.in_b = 5'(acc + 8); bus.in_d = 5'(acc + 16);
         @(negedge CLK);
         if (bus.in_ready) acc++;
         else break;
      end
      chk("fill_accepted", acc, DEPTH + 1);
      @(posedge CLK); #1;
      bus.in_valid = 0;
      bus.RDY_start = 1; bus.RDY_variable_check = 1;
      got = 0;
      for (int c = 0; c < 40 && got < acc; c++) begin
         if (c > 0) begin @(posedge CLK); #1; end
         bus.variable_check = bus.start_a ^ bus.start_b;
         @(negedge CLK);
         if (bus.res_valid) begin
            rd_seen.push_back(bus.res_data);
            t_seen.push_back(c);
            got++;
         end
      end
      chk("drain_count", got, acc);
      for (int i = 0; i < rd_seen.size(); i++)
         chk($sformatf("drain_res%0d", i), rd_seen[i], 5'(i ^ (i + 8)));
      last_t = (t_seen.size() > 0) ? t_seen[0] : 0;
      for (int i = 1; i < t_seen.size(); i++) begin
         chk($sformatf("drain_gap%0d", i), t_seen[i] - last_t, 3);
         last_t = t_seen[i];
      end

      // ---- async reset in CHECK ----
      bus.RDY_start = 1; bus.RDY_variable_check = 0;
      @(posedge CLK); #1;
      bus.in_valid = 1; bus.in_a = 5'h01; bus.in_b = 5'h02; bus.in_d = 5'h03;
      @(posedge CLK); #1;
      bus.in_a = 5'h04; bus.in_b = 5'h05; bus.in_d = 5'h06;
      @(posedge CLK); #1;
      bus.in_valid = 0;
      @(posedge CLK); #1;
      bus.RDY_variable_check = 1;
      #1 chk("rst_pre_en_check", bus.EN_variable_check, 1);
      #1 RST_N = 0;
      #1 chk("rst_mid_outs", outs(), 32'h0000_0002);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_hold_outs", outs(), 32'h0000_0002);
      RST_N = 1;

      add(1, 5'h07, 5'h08, 5'h09, 1, 1, 5'h15, 0, 0, 5'h00, 5'h00, 5'h00, 0, 5'h00, 1, 0);
      add(0, 5'h00, 5'h00, 5'h00, 1, 1, 5'h15, 0, 0, 5'h00, 5'h00, 5'h00, 0, 5'h00, 1, 1);
      add(0, 5'h00, 5'h00, 5'h00, 1, 1, 5'h15, 1, 0, 5'h07, 5'h08, 5'h09, 0, 5'h00, 1, 1);
      add(0, 5'h00, 5'h00, 5'h00, 1, 1, 5'h15, 0, 1, 5'h07, 5'h08, 5'h09, 0, 5'h00, 1, 1);
      add(0, 5'h00, 5'h00, 5'h00, 1, 1, 5'h15, 0, 0, 5'h07, 5'h08, 5'h09, 1, 5'h15, 1, 0);
      run_vecs("post_rst");

      // ---- randomized traffic against the transaction model ----
      for (int c = 0; c < 2000; c++) begin
         @(posedge CLK); #1;
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_a = 5'($urandom); bus.in_b = 5'($urandom); bus.in_d = 5'($urandom);
         bus.RDY_start          = ($urandom_range(0, 3) != 0);
         bus.RDY_variable_check = ($urandom_range(0, 3) != 0);
         bus.variable_check     = 5'($urandom);
         @(negedge CLK);
         sb_cycle();
      end
      cyc = 0;
      while (cyc < 100 && (expq.size() > 0 || pend_v || res_due || bus.busy)) begin
         @(posedge CLK); #1;
         bus.in_valid = 0;
         bus.RDY_start = 1; bus.RDY_variable_check = 1;
         bus.variable_check = 5'($urandom);
         @(negedge CLK);
         sb_cycle();
         cyc++;
      end
      chk("rnd_drained", (expq.size() == 0) && !pend_v && !res_due && !bus.busy, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
